io_responder: RTL and testbench

- Memory-mapped I/O responder sitting at the far end of the CPU's IORead/IOWrite strobes (IO window 0xFFFFFC00–0xFFFFFFFF).
- Holds the board-facing registers: switches, debounced buttons with sticky press events, LEDs, and an 8-digit scanned 7-segment display.
- Returns registered read data to the writeback mux selected by MemorIOToReg.

---
 rtl/io_responder.sv | 152 +++++++++++++++
 tb/tb_io_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_responder.sv
// Memory-mapped I/O responder for the CPU's IO window: switches, debounced buttons with
// sticky events, LEDs and a scanned 8-digit 7-segment display, with registered read data.
module io_responder #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
  parameter logic [16:0] SCAN_DIV        = 17'd100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IORead,
  input  logic        IOWrite,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  input  logic [15:0] sw,
  input  logic [4:0]  btn,
  output logic [15:0] led,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);

  localparam logic [9:0] OFF_SW   = 10'h000;
  localparam logic [9:0] OFF_LVL  = 10'h004;
  localparam logic [9:0] OFF_EVT  = 10'h008;
  localparam logic [9:0] OFF_LED  = 10'h010;
  localparam logic [9:0] OFF_SEGD = 10'h014;
  localparam logic [9:0] OFF_SEGE = 10'h018;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
    endcase
  endfunction

  logic [31:0] io_rdata_q, io_rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] seg_data_q, seg_data_d;
  logic [7:0]  seg_en_q, seg_en_d;
  logic [4:0]  evt_q, evt_d;
  logic [15:0] sw_s1_q, sw_s2_q;
  logic [4:0]  btn_s1_q, btn_s2_q;
  logic [4:0]  btn_db_q, btn_db_d;
  logic [19:0] db_cnt_q [5];
  logic [19:0] db_cnt_d [5];
  logic [16:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  seg_an_q, seg_an_d;
  logic [7:0]  seg_out_q, seg_out_d;

  logic        hit;
  logic [9:0]  off;
  logic        wr;
  logic [31:0] rd_val;
  logic [4:0]  evt_clr;

  assign hit = (io_addr[31:10] == 22'h3FFFFF) && (io_addr[1:0] == 2'b00);
  assign off = io_addr[9:0];
  assign wr  = IOWrite && hit;

  always_comb begin
    rd_val = 32'd0;
    if (hit) begin
      case (off)
        OFF_SW:   rd_val = {16'd0, sw_s2_q};
        OFF_LVL:  rd_val = {27'd0, btn_db_q};
        OFF_EVT:  rd_val = {27'd0, evt_q};
        OFF_LED:  rd_val = {16'd0, led_q};
        OFF_SEGD: rd_val = seg_data_q;
        OFF_SEGE: rd_val = {24'd0, seg_en_q};
        default:  rd_val = 32'd0;
      endcase
    end

    // A combined read+write performs only the write; the read returns zero.
    io_rdata_d = io_rdata_q;
    if (IORead && IOWrite)  io_rdata_d = 32'd0;
    else if (IORead)        io_rdata_d = rd_val;

    led_d      = (wr && off == OFF_LED)  ? io_wdata[15:0] : led_q;
    seg_data_d = (wr && off == OFF_SEGD) ? io_wdata       : seg_data_q;
    seg_en_d   = (wr && off == OFF_SEGE) ? io_wdata[7:0]  : seg_en_q;

    btn_db_d = btn_db_q;
    for (int k = 0; k < 5; k++) begin
      db_cnt_d[k] = 20'd0;
      if (btn_s2_q[k] != btn_db_q[k]) begin
        if (db_cnt_q[k] == DEBOUNCE_CYCLES - 20'd1) btn_db_d[k] = ~btn_db_q[k];
        else                                        db_cnt_d[k] = db_cnt_q[k] + 20'd1;
      end
    end

    // Clears apply first so a rising edge in the same cycle still leaves the bit set.
    evt_clr = 5'd0;
    if (IORead && !IOWrite && hit && off == OFF_EVT) evt_clr = evt_q;
    if (wr && off == OFF_EVT)                        evt_clr = evt_clr | io_wdata[4:0];
    evt_d = (evt_q & ~evt_clr) | (btn_db_d & ~btn_db_q);

    scan_cnt_d = scan_cnt_q + 17'd1;
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_DIV - 17'd1) begin
      scan_cnt_d = 17'd0;
      idx_d      = idx_q + 3'd1;
    end

    seg_an_d  = seg_en_q[idx_q] ? ~(8'd1 << idx_q) : 8'hFF;
    seg_out_d = hex7(seg_data_q[{idx_q, 2'b00} +: 4]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_rdata_q <= 32'd0;
      led_q      <= 16'd0;
      seg_data_q <= 32'd0;
      seg_en_q   <= 8'hFF;
      evt_q      <= 5'd0;
      sw_s1_q    <= 16'd0;
      sw_s2_q    <= 16'd0;
      btn_s1_q   <= 5'd0;
      btn_s2_q   <= 5'd0;
      btn_db_q   <= 5'd0;
      for (int k = 0; k < 5; k++) db_cnt_q[k] <= 20'd0;
      scan_cnt_q <= 17'd0;
      idx_q      <= 3'd0;
      seg_an_q   <= 8'hFE;
      seg_out_q  <= 8'hC0;
    end else begin
      io_rdata_q <= io_rdata_d;
      led_q      <= led_d;
      seg_data_q <= seg_data_d;
      seg_en_q   <= seg_en_d;
      evt_q      <= evt_d;
      sw_s1_q    <= sw;
      sw_s2_q    <= sw_s1_q;
      btn_s1_q   <= btn;
      btn_s2_q   <= btn_s1_q;
      btn_db_q   <= btn_db_d;
      for (int k = 0; k < 5; k++) db_cnt_q[k] <= db_cnt_d[k];
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_an_q   <= seg_an_d;
      seg_out_q  <= seg_out_d;
    end
  end

  assign io_rdata = io_rdata_q;
  assign led      = led_q;
  assign seg_an   = seg_an_q;
  assign seg_out  = seg_out_q;

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: a register/event/scan reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_io_responder;

  localparam int DB = 4;
  localparam int SD = 2;
  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        IORead = 1'b0;
  logic        IOWrite = 1'b0;
  logic [31:0] io_addr = 32'd0;
  logic [31:0] io_wdata = 32'd0;
  logic [31:0] io_rdata;
  logic [15:0] sw = 16'd0;
  logic [4:0]  btn = 5'd0;
  logic [15:0] led;
  logic [7:0]  seg_an;
  logic [7:0]  seg_out;

  io_responder #(.DEBOUNCE_CYCLES(20'd4), .SCAN_DIV(17'd2)) dut (
    .clk(clk), .rst_n(rst_n), .IORead(IORead), .IOWrite(IOWrite), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .sw(sw), .btn(btn), .led(led),
    .seg_an(seg_an), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents, sync delay lines, stable-run counts, edge count.
  logic [31:0] m_rdata, m_seg_data;
  logic [15:0] m_led, m_sw_a, m_sw_b;
  logic [7:0]  m_seg_en, m_an, m_out;
  logic [4:0]  m_evt, m_db, m_btn_a, m_btn_b;
  int          m_run [5];
  int          m_k;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] rv;
    logic [4:0]  ndb, clr;
    logic        mhit;
    int          slot;
    if (!rst_n) begin
      m_rdata = 0; m_seg_data = 0; m_led = 0; m_sw_a = 0; m_sw_b = 0;
      m_seg_en = 8'hFF; m_an = 8'hFE; m_out = 8'hC0;
      m_evt = 0; m_db = 0; m_btn_a = 0; m_btn_b = 0; m_k = 0;
      for (int k = 0; k < 5; k++) m_run[k] = 0;
    end else begin
      mhit = (io_addr >= 32'hFFFFFC00) && (io_addr % 4 == 0);
      rv = 0;
      if (mhit) begin
        if (io_addr == 32'hFFFFFC00) rv = {16'd0, m_sw_b};
        if (io_addr == 32'hFFFFFC04) rv = {27'd0, m_db};
        if (io_addr == 32'hFFFFFC08) rv = {27'd0, m_evt};
        if (io_addr == 32'hFFFFFC10) rv = {16'd0, m_led};
        if (io_addr == 32'hFFFFFC14) rv = m_seg_data;
        if (io_addr == 32'hFFFFFC18) rv = {24'd0, m_seg_en};
      end
      if (IORead && IOWrite) m_rdata = 0;
      else if (IORead)       m_rdata = rv;

      ndb = m_db;
      for (int k = 0; k < 5; k++) begin
        if (m_btn_b[k] != m_db[k]) begin
          if (m_run[k] == DB - 1) begin ndb[k] = ~m_db[k]; m_run[k] = 0; end
          else m_run[k] = m_run[k] + 1;
        end else m_run[k] = 0;
      end
      clr = 0;
      if (IORead && !IOWrite && io_addr == 32'hFFFFFC08) clr = m_evt;
      if (IOWrite && io_addr == 32'hFFFFFC08)            clr = clr | io_wdata[4:0];
      m_evt = (m_evt & ~clr) | (ndb & ~m_db);
      m_db = ndb;

      slot  = (m_k / SD) % 8;
      m_an  = m_seg_en[slot] ? ~(8'd1 << slot) : 8'hFF;
      m_out = HEX[(m_seg_data >> (4 * slot)) & 32'hF];
      m_k   = m_k + 1;

      if (IOWrite && io_addr == 32'hFFFFFC10) m_led = io_wdata[15:0];
      if (IOWrite && io_addr == 32'hFFFFFC14) m_seg_data = io_wdata;
      if (IOWrite && io_addr == 32'hFFFFFC18) m_seg_en = io_wdata[7:0];

      m_sw_b = m_sw_a;   m_sw_a = sw;
      m_btn_b = m_btn_a; m_btn_a = btn;
    end
  end

  always @(negedge clk) begin
    chk("model_rdata", io_rdata, m_rdata);
    chk("model_led", {16'd0, led}, {16'd0, m_led});
    chk("model_seg_an", {24'd0, seg_an}, {24'd0, m_an});
    chk("model_seg_out", {24'd0, seg_out}, {24'd0, m_out});
  end

  task automatic io_wr(input logic [31:0] a, input logic [31:0] d);
    IOWrite = 1'b1; io_addr = a; io_wdata = d;
    @(negedge clk);
    IOWrite = 1'b0;
  endtask

  task automatic io_rd(input logic [31:0] a);
    IORead = 1'b1; io_addr = a;
    @(negedge clk);
    IORead = 1'b0;
  endtask

  task automatic wait_an(input logic [7:0] v, input bit want_eq, input string name);
    int n = 0;
    while (((seg_an == v) != want_eq) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL %s timeout seg_an=%h waiting for %h", name, seg_an, v);
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", io_rdata, 32'd0);
    chk("rst_led", {16'd0, led}, 32'd0);
    chk("rst_seg_an", {24'd0, seg_an}, 32'hFE);
    chk("rst_seg_out", {24'd0, seg_out}, 32'hC0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    io_wr(32'hFFFFFC10, 32'h0000A5A5);
    chk("led_write", {16'd0, led}, 32'h0000A5A5);
    io_rd(32'hFFFFFC10);
    chk("led_read", io_rdata, 32'h0000A5A5);

    sw = 16'h1234;
    repeat (3) @(negedge clk);
    io_rd(32'hFFFFFC00);
    chk("sw_read", io_rdata, 32'h00001234);

    btn[2] = 1'b1;
    repeat (2) @(negedge clk);
    btn[2] = 1'b0;
    repeat (6) @(negedge clk);
    io_rd(32'hFFFFFC04);
    chk("bounce_level", io_rdata, 32'd0);
    io_rd(32'hFFFFFC08);
    chk("bounce_evt", io_rdata, 32'd0);

    btn[2] = 1'b1;
    repeat (6) @(negedge clk);
    io_rd(32'hFFFFFC04);
    chk("held_level", io_rdata, 32'h4);
    io_rd(32'hFFFFFC08);
    chk("evt_first_read", io_rdata, 32'h4);
    io_rd(32'hFFFFFC08);
    chk("evt_second_read", io_rdata, 32'h0);

    btn[0] = 1'b1;
    repeat (5) @(negedge clk);
    io_rd(32'hFFFFFC08);
    chk("evt_race_read", io_rdata, 32'h0);
    io_rd(32'hFFFFFC08);
    chk("evt_race_kept", io_rdata, 32'h1);

    io_wr(32'hFFFFFC14, 32'h76543210);
    io_wr(32'hFFFFFC18, 32'h000000FD);
    wait_an(8'hFE, 1'b0, "scan_leave0");
    wait_an(8'hFE, 1'b1, "scan_enter0");
    chk("digit0_an", {24'd0, seg_an}, 32'hFE);
    chk("digit0_seg", {24'd0, seg_out}, 32'hC0);
    repeat (SD) @(negedge clk);
    chk("digit1_off", {24'd0, seg_an}, 32'hFF);
    repeat (SD) @(negedge clk);
    chk("digit2_an", {24'd0, seg_an}, 32'hFB);
    chk("digit2_seg", {24'd0, seg_out}, 32'hA4);
    repeat (6 * SD) @(negedge clk);
    chk("wrap_an", {24'd0, seg_an}, 32'hFE);
    chk("wrap_seg", {24'd0, seg_out}, 32'hC0);

    io_wr(32'hFFFFFC20, 32'h0000FFFF);
    io_wr(32'hFFFFFC11, 32'h00001111);
    chk("unmapped_led", {16'd0, led}, 32'h0000A5A5);
    io_rd(32'hFFFFFC10);
    chk("led_reread", io_rdata, 32'h0000A5A5);
    io_rd(32'hFFFFFC20);
    chk("unmapped_read", io_rdata, 32'd0);
    io_rd(32'hFFFFFC18);
    chk("segen_kept", io_rdata, 32'hFD);
    IORead = 1'b1;
    io_wr(32'hFFFFFC10, 32'h00005A5A);
    IORead = 1'b0;
    chk("rw_led", {16'd0, led}, 32'h00005A5A);
    chk("rw_rdata", io_rdata, 32'd0);

    io_rd(32'hFFFFFC14);
    wait_an(8'hFE, 1'b0, "scan_before_rst");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", {24'd0, seg_an}, 32'hFE);
    chk("async_rst_led", {16'd0, led}, 32'd0);
    chk("async_rst_rdata", io_rdata, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    io_rd(32'hFFFFFC14);
    chk("rst_segdata", io_rdata, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
